// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: opcode layout and funct3 load encodings.
`ifndef WRITEBACK_STAGE_DEFS
`define WRITEBACK_STAGE_DEFS
`define OPCODE_WIDTH 11
`define LOAD 1
`endif

package writeback_stage_pkg;
    localparam int OPCODE_WIDTH = `OPCODE_WIDTH;
    localparam int OP_LOAD_BIT  = `LOAD;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword/word and extends it.
module wb_load_align
    import writeback_stage_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic [DWIDTH-1:0]      word_i,
    input  logic [1:0]             byte_off_i,
    input  logic [FUNCT_WIDTH-1:0] funct3_i,
    output logic [DWIDTH-1:0]      ext_data_o,
    output logic                   bad_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (byte_off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        ext_data_o = '0;
        bad_o      = 1'b0;
        case (funct3_i[2:0])
            F3_LB:  ext_data_o = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU: ext_data_o = {{(DWIDTH-8){1'b0}}, byte_sel};
            F3_LH: begin
                ext_data_o = {{(DWIDTH-16){half_sel[15]}}, half_sel};
                bad_o      = byte_off_i[0];
            end
            F3_LHU: begin
                ext_data_o = {{(DWIDTH-16){1'b0}}, half_sel};
                bad_o      = byte_off_i[0];
            end
            F3_LW: begin
                ext_data_o = word_i;
                bad_o      = (byte_off_i != 2'd0);
            end
            // 011/110/111 have no load meaning; reject like a misalignment.
            default: bad_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects ALU or load result, drives the register-file write
// port one cycle later, counts retired instructions and flags rejected loads.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int FUNCT_WIDTH = 3,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,
    input  logic                     wb_i_ce,
    input  logic                     wb_i_stall,
    input  logic                     wb_i_flush,
    input  logic [`OPCODE_WIDTH-1:0] wb_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]   wb_i_funct3,
    input  logic [AWIDTH-1:0]        wb_i_rd_addr,
    input  logic [DWIDTH-1:0]        wb_i_rd_data,
    input  logic                     wb_i_rd_we,
    input  logic [DWIDTH-1:0]        wb_i_load_data,
    input  logic [1:0]               wb_i_byte_off,
    output logic [AWIDTH-1:0]        wb_o_rd_addr,
    output logic [DWIDTH-1:0]        wb_o_rd_data,
    output logic                     wb_o_rd_we,
    output logic                     wb_o_ce,
    output logic                     wb_o_misalign,
    output logic [CNT_WIDTH-1:0]     wb_o_retired
);
    logic              acc;
    logic              is_load;
    logic [DWIDTH-1:0] ext_data;
    logic              bad;
    logic [DWIDTH-1:0] data_d;
    logic              we_d;
    logic              mis_d;

    logic [AWIDTH-1:0]    addr_q;
    logic [DWIDTH-1:0]    data_q;
    logic                 we_q;
    logic                 ce_q;
    logic                 mis_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    wb_load_align #(
        .DWIDTH      (DWIDTH),
        .FUNCT_WIDTH (FUNCT_WIDTH)
    ) u_align (
        .word_i     (wb_i_load_data),
        .byte_off_i (wb_i_byte_off),
        .funct3_i   (wb_i_funct3),
        .ext_data_o (ext_data),
        .bad_o      (bad)
    );

    assign acc     = wb_i_ce & ~wb_i_stall & ~wb_i_flush;
    assign is_load = wb_i_opcode[`LOAD];

    always_comb begin
        data_d = is_load ? ext_data : wb_i_rd_data;
        mis_d  = is_load & bad;
        we_d   = (is_load ? ~bad : wb_i_rd_we) & (wb_i_rd_addr != '0);
    end

    // Pulses are cleared whenever nothing is accepted, so a held instruction never
    // writes or retires twice; address/data simply hold.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            ce_q   <= 1'b0;
            mis_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            we_q  <= acc & we_d;
            ce_q  <= acc;
            mis_q <= acc & mis_d;
            if (acc) begin
                addr_q <= wb_i_rd_addr;
                data_q <= data_d;
                cnt_q  <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign wb_o_rd_addr  = addr_q;
    assign wb_o_rd_data  = data_q;
    assign wb_o_rd_we    = we_q;
    assign wb_o_ce       = ce_q;
    assign wb_o_misalign = mis_q;
    assign wb_o_retired  = cnt_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push expectations, a monitor
// compares them whenever an instruction retires and checks quiet/hold behaviour otherwise.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, stall, flush;
    logic [10:0] opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_we;
    logic [31:0] load_data;
    logic [1:0]  byte_off;
    logic [4:0]  o_addr;
    logic [31:0] o_data;
    logic        o_we, o_ce, o_mis;
    logic [CW-1:0] o_ret;

    typedef struct {
        logic [4:0]    addr;
        logic [31:0]   data;
        bit            chk_data;
        logic          we;
        logic          mis;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    logic [CW-1:0] exp_cnt;
    int checks = 0;
    int fails  = 0;
    bit rst_d  = 1'b0;

    logic [4:0]    held_addr;
    logic [31:0]   held_data;
    bit            held_data_ok;
    logic [CW-1:0] held_cnt;

    always #5 clk = ~clk;

    writeback_stage #(
        .DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3), .CNT_WIDTH(CW)
    ) dut (
        .wb_clk(clk), .wb_rst(rst), .wb_i_ce(ce), .wb_i_stall(stall), .wb_i_flush(flush),
        .wb_i_opcode(opcode), .wb_i_funct3(funct3), .wb_i_rd_addr(rd_addr),
        .wb_i_rd_data(rd_data), .wb_i_rd_we(rd_we), .wb_i_load_data(load_data),
        .wb_i_byte_off(byte_off), .wb_o_rd_addr(o_addr), .wb_o_rd_data(o_data),
        .wb_o_rd_we(o_we), .wb_o_ce(o_ce), .wb_o_misalign(o_mis), .wb_o_retired(o_ret)
    );

    always @(posedge clk) rst_d <= rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: pop on retire, otherwise require silent pulses and held outputs.
    always @(negedge clk) begin
        exp_t e;
        if (rst_d) begin
            check("rst_we", 32'(o_we), 0);
            check("rst_ce", 32'(o_ce), 0);
            check("rst_mis", 32'(o_mis), 0);
            check("rst_addr", 32'(o_addr), 0);
            check("rst_data", o_data, 0);
            check("rst_retired", 32'(o_ret), 0);
            held_addr = '0; held_data = '0; held_data_ok = 1'b1; held_cnt = '0;
        end else if (o_ce === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_retire", 32'(o_ce), 0);
            end else begin
                e = exp_q.pop_front();
                check("addr", 32'(o_addr), 32'(e.addr));
                if (e.chk_data) check("data", o_data, e.data);
                check("rd_we", 32'(o_we), 32'(e.we));
                check("misalign", 32'(o_mis), 32'(e.mis));
                check("retired", 32'(o_ret), 32'(e.cnt));
                $display("retire rd=%0d data=0x%08h we=%0b mis=%0b retired=%0d",
                         o_addr, o_data, o_we, o_mis, o_ret);
                held_addr = e.addr; held_data = e.data; held_data_ok = e.chk_data;
                held_cnt = e.cnt;
            end
        end else if (rst === 1'b0) begin
            check("idle_we", 32'(o_we), 0);
            check("idle_mis", 32'(o_mis), 0);
            check("hold_addr", 32'(o_addr), 32'(held_addr));
            if (held_data_ok) check("hold_data", o_data, held_data);
            check("hold_retired", 32'(o_ret), 32'(held_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input bit cd,
                        input logic w, input logic m);
        exp_t e;
        exp_cnt = exp_cnt + 1'b1;
        e.addr = a; e.data = d; e.chk_data = cd; e.we = w; e.mis = m; e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d, input logic w,
                       input logic exp_we);
        ce = 1; stall = 0; flush = 0; opcode = 11'b1; funct3 = 3'b000;
        rd_addr = a; rd_data = d; rd_we = w; load_data = 32'h0; byte_off = 2'd0;
        push(a, d, 1'b1, exp_we, 1'b0);
        step();
    endtask

    task automatic load(input logic [2:0] f3, input logic [4:0] a, input logic [31:0] w,
                        input logic [1:0] off, input logic [31:0] exp_d,
                        input logic exp_we, input logic exp_mis);
        ce = 1; stall = 0; flush = 0; opcode = 11'b0;
        opcode[OP_LOAD_BIT] = 1'b1;
        funct3 = f3; rd_addr = a; rd_data = 32'h5555_5555; rd_we = 0;
        load_data = w; byte_off = off;
        push(a, exp_d, !exp_mis, exp_we, exp_mis);
        step();
    endtask

    task automatic hold(input logic c, input logic s, input logic f);
        ce = c; stall = s; flush = f;
        step();
    endtask

    initial begin
        rst = 1; ce = 0; stall = 0; flush = 0; opcode = '0; funct3 = '0;
        rd_addr = '0; rd_data = '0; rd_we = 0; load_data = '0; byte_off = '0;
        exp_cnt = '0;
        held_addr = '0; held_data = '0; held_data_ok = 1'b1; held_cnt = '0;
        step(); step();
        rst = 0;
        hold(0, 0, 0);

        alu(5'd5, 32'h0000_1234, 1, 1);
        load(F3_LB,  5'd6, 32'h80FF_7F01, 2'd3, 32'hFFFF_FF80, 1, 0);
        load(F3_LBU, 5'd7, 32'h80FF_7F01, 2'd3, 32'h0000_0080, 1, 0);
        load(F3_LB,  5'd8, 32'h80FF_7F01, 2'd1, 32'h0000_007F, 1, 0);
        load(F3_LH,  5'd9, 32'h80FF_7F01, 2'd1, 32'h0, 0, 1);
        load(F3_LH,  5'd10, 32'h80FF_7F01, 2'd2, 32'hFFFF_80FF, 1, 0);
        load(F3_LHU, 5'd11, 32'h80FF_7F01, 2'd0, 32'h0000_7F01, 1, 0);
        load(F3_LW,  5'd12, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 1, 0);
        load(F3_LW,  5'd13, 32'hDEAD_BEEF, 2'd2, 32'h0, 0, 1);
        load(3'b011, 5'd14, 32'hDEAD_BEEF, 2'd0, 32'h0, 0, 1);
        alu(5'd15, 32'hCAFE_F00D, 0, 0);

        // Instruction held under stall for three cycles, then flushed with stall.
        alu(5'd16, 32'hA5A5_0001, 1, 1);
        rd_addr = 5'd17; rd_data = 32'h1111_2222;
        hold(1, 1, 0); hold(1, 1, 0); hold(1, 1, 0);
        hold(1, 1, 1);
        hold(1, 0, 1);
        hold(0, 0, 0);

        alu(5'd0, 32'h0BAD_0000, 1, 0);
        load(F3_LW, 5'd0, 32'h1234_5678, 2'd0, 32'h1234_5678, 0, 0);

        // Reset lands on an accepted instruction; it must not appear.
        ce = 1; stall = 0; flush = 0; opcode = 11'b1; rd_addr = 5'd20;
        rd_data = 32'h7777_7777; rd_we = 1; rst = 1;
        step();
        rst = 0; ce = 0;
        exp_cnt = '0;
        hold(0, 0, 0);

        for (int i = 1; i <= 16; i++)
            alu(5'(i), 32'h100 + 32'(i), 1, 1);
        hold(0, 0, 0);
        hold(0, 0, 0);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
